// File: rtl/irq_dispatch.sv
// Per-tile interrupt dispatcher. It captures rising edges on 16 lines and arbitrates by fixed
// priority with in-service nesting. Dispatch is a one-cycle irqload pulse, then a minimum idle gap.
module irq_dispatch #(
  parameter int unsigned GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irq_src,
  input  logic        hold,
  input  logic        mask_we,
  input  logic [15:0] mask_wdata,
  input  logic        eoi,
  input  logic [3:0]  eoi_num,
  output logic        irqload,
  output logic [3:0]  irqnum,
  output logic [15:0] pending,
  output logic [15:0] in_service,
  output logic [15:0] mask,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] src_q;
  logic [15:0] pend_q, pend_d;
  logic [15:0] isr_q, isr_d;
  logic [15:0] mask_q, mask_d;
  logic        irqload_q, irqload_d;
  logic [3:0]  irqnum_q, irqnum_d;
  logic        busy_q, busy_d;

  logic [15:0] edges;
  logic [15:0] elig;
  logic        blocked;
  logic [3:0]  cand;
  logic        cand_valid;
  logic        fire;

  assign edges = irq_src & ~src_q;

  // A line is blocked once any line of equal or higher priority (lower index) is in service.
  always_comb begin
    elig    = '0;
    blocked = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      blocked = blocked | isr_q[i];
      elig[i] = pend_q[i] & ~mask_q[i] & ~blocked;
    end
  end

  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (elig[i-1]) begin
        cand       = 4'(i - 1);
        cand_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    irqload_d = 1'b0;
    irqnum_d  = irqnum_q;
    fire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid && !hold) begin
          fire      = 1'b1;
          irqload_d = 1'b1;
          irqnum_d  = cand;
          state_d   = ST_FIRE;
        end
      end
      ST_FIRE: begin
        cnt_d   = 8'(GAP - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FIRE) || (state_d == ST_GAP);
  end

  // A new edge is OR-ed in last, so it wins over the dispatch clear on the same bit.
  always_comb begin
    pend_d = pend_q;
    isr_d  = isr_q;
    if (eoi) begin
      isr_d[eoi_num] = 1'b0;
    end
    if (fire) begin
      pend_d[cand] = 1'b0;
      isr_d[cand]  = 1'b1;
    end
    pend_d = pend_d | edges;
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    src_q <= irq_src;
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
      mask_q    <= '1;
      irqload_q <= 1'b0;
      irqnum_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      mask_q    <= mask_d;
      irqload_q <= irqload_d;
      irqnum_q  <= irqnum_d;
      busy_q    <= busy_d;
    end
  end

  assign irqload    = irqload_q;
  assign irqnum     = irqnum_q;
  assign pending    = pend_q;
  assign in_service = isr_q;
  assign mask       = mask_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch. A cycle-indexed reference model tracks pulse timing as
// arithmetic on the last pulse cycle. Directed scenarios come first, then random traffic.
module tb_irq_dispatch;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_src;
  logic        hold;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        eoi;
  logic [3:0]  eoi_num;
  logic        irqload;
  logic [3:0]  irqnum;
  logic [15:0] pending;
  logic [15:0] in_service;
  logic [15:0] mask;
  logic        busy;

  irq_dispatch #(.GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .hold       (hold),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .eoi        (eoi),
    .eoi_num    (eoi_num),
    .irqload    (irqload),
    .irqnum     (irqnum),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycle c is the cycle that follows clock edge c.
  int          cyc    = 0;
  int          m_last = -1000;
  logic [15:0] m_pend = '0;
  logic [15:0] m_isr  = '0;
  logic [15:0] m_mask = '1;
  logic [15:0] m_src  = '0;
  logic        m_load = 1'b0;
  logic [3:0]  m_num  = '0;
  logic        m_busy = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [15:0] e, fb, eb, upto;
    int          cand;
    bit          found, can_fire, fire;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pend = '0;
      m_isr  = '0;
      m_mask = '1;
      m_src  = irq_src;
      m_load = 1'b0;
      m_num  = '0;
      m_last = -1000;
    end else begin
      e     = irq_src & ~m_src;
      found = 0;
      cand  = 0;
      for (int i = 15; i >= 0; i--) begin
        upto = 16'((32'd2 << i) - 1);
        if (m_pend[i] && !m_mask[i] && ((m_isr & upto) == 16'h0)) begin
          found = 1;
          cand  = i;
        end
      end
      // Dispatch is allowed only if the previous cycle lay outside the pulse+gap window.
      can_fire = (cyc - 1) > (m_last + GAP);
      fire     = found && can_fire && !hold;
      fb       = fire ? 16'(1 << cand) : 16'h0;
      eb       = eoi ? 16'(1 << eoi_num) : 16'h0;
      m_pend   = (m_pend & ~fb) | e;
      m_isr    = (m_isr & ~eb) | fb;
      if (mask_we) m_mask = mask_wdata;
      m_src  = irq_src;
      m_load = fire;
      if (fire) begin
        m_num  = 4'(cand);
        m_last = cyc;
      end
    end
    m_busy = (cyc >= m_last) && (cyc <= m_last + GAP);
    #1;
    check("irqload", 16'(irqload), 16'(m_load));
    check("irqnum", 16'(irqnum), 16'(m_num));
    check("pending", pending, m_pend);
    check("in_service", in_service, m_isr);
    check("mask", mask, m_mask);
    check("busy", 16'(busy), 16'(m_busy));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_eoi(input logic [3:0] num);
    eoi     = 1'b1;
    eoi_num = num;
    step();
    eoi     = 1'b0;
  endtask

  task automatic write_mask(input logic [15:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    step();
    mask_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst        = 1'b1;
    irq_src    = '0;
    hold       = 1'b0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    eoi        = 1'b0;
    eoi_num    = '0;

    // Reset state
    run(2);
    check("rst_mask", mask, 16'hFFFF);
    check("rst_irqload", 16'(irqload), 16'h0);
    rst = 1'b0;
    step();

    // Basic dispatch on line 5
    write_mask(16'h0000);
    irq_src = 16'h0020;
    step();
    check("basic_pending", pending, 16'h0020);
    step();
    check("basic_irqload", 16'(irqload), 16'h1);
    check("basic_irqnum", 16'(irqnum), 16'd5);
    check("basic_isr", in_service, 16'h0020);
    run(12);
    do_eoi(4'd5);
    irq_src = '0;
    run(2);

    // Priority: lines 3 and 9 together; 9 waits on eoi of 3
    irq_src = 16'h0208;
    run(2);
    check("prio_irqnum", 16'(irqnum), 16'd3);
    run(20);
    check("prio_isr", in_service, 16'h0008);
    check("prio_pend", pending, 16'h0200);
    do_eoi(4'd3);
    run(15);
    irq_src = '0;

    // Nesting: 2 preempts under 9; 12 waits on both
    irq_src = 16'h0004;
    run(14);
    check("nest_isr", in_service, 16'h0204);
    irq_src = 16'h1004;
    run(20);
    check("nest_pend12", pending, 16'h1000);
    do_eoi(4'd2);
    run(12);
    check("nest_still12", pending, 16'h1000);
    do_eoi(4'd9);
    run(12);
    check("nest_isr12", in_service, 16'h1000);
    do_eoi(4'd12);
    irq_src = '0;
    run(2);

    // Mask and hold
    do_reset();
    irq_src = 16'h0001;
    step();
    run(4);
    check("mh_pend", pending, 16'h0001);
    hold = 1'b1;
    write_mask(16'h0000);
    run(5);
    hold = 1'b0;
    step();
    check("mh_irqload", 16'(irqload), 16'h1);
    check("mh_irqnum", 16'(irqnum), 16'd0);
    run(12);
    do_eoi(4'd0);
    irq_src = '0;
    run(2);

    // Second rising edge on line 4 exactly at its dispatch edge
    hold    = 1'b1;
    irq_src = 16'h0010;
    step();
    irq_src = 16'h0000;
    run(3);
    hold    = 1'b0;
    irq_src = 16'h0010;
    step();
    check("re_irqload", 16'(irqload), 16'h1);
    check("re_irqnum", 16'(irqnum), 16'd4);
    check("re_pend", pending, 16'h0010);
    run(12);
    do_eoi(4'd7);
    check("eoi7_isr", in_service, 16'h0010);
    do_eoi(4'd4);
    run(12);
    do_eoi(4'd4);
    irq_src = '0;
    run(2);

    // Lines held high through reset release
    irq_src = 16'hFFFF;
    do_reset();
    run(2);
    check("hi_pend", pending, 16'h0000);
    write_mask(16'h0000);
    run(3);

    // Reset three cycles into the gap
    irq_src = 16'h0000;
    step();
    irq_src = 16'h0002;
    run(2);
    run(3);
    rst = 1'b1;
    step();
    check("mg_irqload", 16'(irqload), 16'h0);
    check("mg_mask", mask, 16'hFFFF);
    check("mg_busy", 16'(busy), 16'h0);
    check("mg_isr", in_service, 16'h0000);
    rst     = 1'b0;
    irq_src = 16'h00F0;
    run(20);
    irq_src = '0;
    write_mask(16'h0000);
    run(12);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ 16'(1 << $urandom_range(0, 15));
      hold    = ($urandom_range(0, 3) == 0);
      eoi     = ($urandom_range(0, 4) == 0);
      eoi_num = 4'($urandom_range(0, 15));
      if (eoi && m_isr != 16'h0 && $urandom_range(0, 3) != 0) begin
        for (int i = 15; i >= 0; i--) if (m_isr[i]) eoi_num = 4'(i);
      end
      mask_we    = ($urandom_range(0, 40) == 0);
      mask_wdata = 16'($urandom & $urandom & $urandom);
      rst        = ($urandom_range(0, 700) == 0);
      if (rst) mask_we = 1'b0;
      step();
      if (rst) begin
        rst = 1'b0;
        write_mask(16'h0000);
      end
    end
    rst     = 1'b0;
    eoi     = 1'b0;
    mask_we = 1'b0;
    hold    = 1'b0;
    run(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
